// File: rtl/gray_pkg.sv
// rtl/gray_pkg.sv - shared types and gray/binary conversion helpers for gray_meas_ctrl
//
// Purpose: state encoding for the measurement controller and width-generic
//          gray<->binary conversions. Values are carried in 32-bit containers;
//          only the low 'width' bits are meaningful (width must be 1..32).
// Contents:
//   gmc_state_t  controller state enum
//   gray2bin     gray code to binary, low 'width' bits
//   bin2gray     binary to gray code, low 'width' bits

package gray_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } gmc_state_t;

    function automatic logic [31:0] gray2bin(input logic [31:0] g, input int width);
        logic [31:0] b;
        b     = '0;
        b[31] = (width >= 32) ? g[31] : 1'b0;
        // Bits above width-1 stay zero, so the MSB of the field copies g directly.
        for (int i = 30; i >= 0; i--) begin
            if (i < width) begin
                b[i] = b[i + 1] ^ g[i];
            end
        end
        return b;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b, input int width);
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (b ^ (b >> 1)) & mask;
    endfunction

endpackage

// File: rtl/gray_step_check.sv
// rtl/gray_step_check.sv - checks consecutive counter samples for a legal +1 step
//
// Purpose: holds the previous binary sample and flags any sample that is not
//          the previous value plus one (modulo 2^WIDTH), and flags the
//          all-ones to zero wrap. The reference sample is stored, not checked.
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   sample_en  in   a valid sample is present this cycle
//   is_ref     in   this sample is the reference (no check)
//   bin        in   current binary sample, WIDTH bits
//   err_step   out  combinational: sample is not prev+1
//   wrap       out  combinational: prev was all-ones and sample is zero

module gray_step_check #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_en,
    input  logic             is_ref,
    input  logic [WIDTH-1:0] bin,
    output logic             err_step,
    output logic             wrap
);

    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;

    always_comb begin
        err_step = 1'b0;
        wrap     = 1'b0;
        prev_d   = prev_q;
        if (sample_en) begin
            prev_d = bin;
            if (!is_ref) begin
                err_step = (bin != (prev_q + WIDTH'(1)));
                wrap     = (prev_q == '1) && (bin == '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/gray_meas_ctrl.sv
// rtl/gray_meas_ctrl.sv - start/stop sequencer and result capture for a gray-code duration timer
//
// Purpose: holds the external gray counter cleared while idle, releases it on
//          start, verifies every sample is a +1 step, captures the decoded
//          count on stop and offers it through a valid/ready handshake.
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset
//   start      in   begin measurement (IDLE only)
//   stop       in   end measurement (RUN only)
//   gray_in    in   gray-coded counter output, WIDTH bits
//   cnt_reset  out  registered counter clear
//   busy       out  registered, high outside IDLE
//   res_valid  out  registered, result available
//   res_ready  in   consumer accepts result
//   res_bin    out  captured binary count, WIDTH bits
//   res_err    out  sticky illegal-step flag
//   res_ovf    out  sticky wrap flag

module gray_meas_ctrl
    import gray_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] gray_in,
    output logic             cnt_reset,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_bin,
    output logic             res_err,
    output logic             res_ovf
);

    gmc_state_t       state_q, state_d;
    logic [3:0]       settle_q, settle_d;
    logic             ref_q, ref_d;
    logic [WIDTH-1:0] res_bin_q, res_bin_d;
    logic             res_err_q, res_err_d;
    logic             res_ovf_q, res_ovf_d;
    logic             cnt_reset_q, cnt_reset_d;
    logic             busy_q, busy_d;
    logic             res_valid_q, res_valid_d;

    logic [WIDTH-1:0] cur_bin;
    logic             sample_en;
    logic             err_step;
    logic             wrap;

    assign cur_bin   = WIDTH'(gray2bin(32'(gray_in), WIDTH));
    assign sample_en = (state_q == ST_RUN);

    gray_step_check #(
        .WIDTH(WIDTH)
    ) u_step_check (
        .clk      (clk),
        .reset    (reset),
        .sample_en(sample_en),
        .is_ref   (ref_q),
        .bin      (cur_bin),
        .err_step (err_step),
        .wrap     (wrap)
    );

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        ref_d     = ref_q;
        res_bin_d = res_bin_q;
        res_err_d = res_err_q;
        res_ovf_d = res_ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                // start outranks a simultaneous stop; stop has no meaning here.
                if (start) begin
                    state_d   = ST_SETTLE;
                    res_err_d = 1'b0;
                    res_ovf_d = 1'b0;
                    settle_d  = 4'(SETTLE_CYCLES - 1);
                end
            end
            ST_SETTLE: begin
                if (settle_q == 4'd0) begin
                    state_d = ST_RUN;
                    ref_d   = 1'b1;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            ST_RUN: begin
                ref_d = 1'b0;
                // Flags include this cycle's step so a bad final sample is reported.
                if (err_step) res_err_d = 1'b1;
                if (wrap)     res_ovf_d = 1'b1;
                if (stop) begin
                    res_bin_d = cur_bin;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they change on the
        // same edge as the state transition.
        cnt_reset_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
        res_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            settle_q    <= 4'd0;
            ref_q       <= 1'b0;
            res_bin_q   <= '0;
            res_err_q   <= 1'b0;
            res_ovf_q   <= 1'b0;
            cnt_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            ref_q       <= ref_d;
            res_bin_q   <= res_bin_d;
            res_err_q   <= res_err_d;
            res_ovf_q   <= res_ovf_d;
            cnt_reset_q <= cnt_reset_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign cnt_reset = cnt_reset_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_bin   = res_bin_q;
    assign res_err   = res_err_q;
    assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_gray_meas_ctrl.sv
// tb/tb_gray_meas_ctrl.sv - scoreboard bench for gray_meas_ctrl

module tb_gray_meas_ctrl;
    import gray_pkg::*;

    localparam int W = 8;
    localparam int S = 1;

    typedef struct packed {
        logic [W-1:0] bin;
        logic         err;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, start, stop, res_ready;
    logic [W-1:0] gray_in;
    logic         cnt_reset, busy, res_valid, res_err, res_ovf;
    logic [W-1:0] res_bin;

    logic         start3, stop3, ready3;
    logic [W-1:0] gray3;
    logic         cr3, busy3, rv3, re3, ro3;
    logic [W-1:0] rb3;

    int total = 0;
    int bad   = 0;

    exp_t        exp_q[$];
    int unsigned samp[$];

    gray_meas_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .gray_in(gray_in),
        .cnt_reset(cnt_reset), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_bin(res_bin), .res_err(res_err), .res_ovf(res_ovf)
    );

    gray_meas_ctrl #(.WIDTH(W), .SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .stop(stop3), .gray_in(gray3),
        .cnt_reset(cr3), .busy(busy3), .res_valid(rv3), .res_ready(ready3),
        .res_bin(rb3), .res_err(re3), .res_ovf(ro3)
    );

    // Behavioural gray counter: internal count cleared by cnt_reset, output
    // register one cycle behind. skip_en jumps the emitted value by one from 10 on.
    logic [W-1:0] c_int, v1, adj, c3;
    logic         skip_en;

    always_comb adj = (skip_en && c_int >= W'(10)) ? c_int + W'(1) : c_int;

    always @(posedge clk) begin
        if (cnt_reset) c_int <= '0;
        else           c_int <= c_int + W'(1);
        v1      <= adj;
        gray_in <= W'(bin2gray(32'(adj), W));
        if (cr3) c3 <= '0;
        else     c3 <= c3 + W'(1);
        gray3 <= W'(bin2gray(32'(c3), W));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: compares every accepted result against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got res_bin=%0d expected no result", res_bin);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_bin", 32'(res_bin), 32'(e.bin));
                    chk("res_err", 32'(res_err), 32'(e.err));
                    chk("res_ovf", 32'(res_ovf), 32'(e.ovf));
                end
            end
        end
    end

    task automatic measure(input int k, input bit skp, input bit hold, input bit sws,
                           input bit use_c, input exp_t cexp);
        exp_t e;
        skip_en = skp;
        samp.delete();
        @(negedge clk);
        chk("idle_cnt_reset", 32'(cnt_reset), 1);
        chk("idle_busy", 32'(busy), 0);
        start = 1'b1;
        stop  = sws;
        @(negedge clk);
        start = 1'b0;
        stop  = 1'b0;
        chk("settle_cnt_reset", 32'(cnt_reset), 0);
        chk("settle_busy", 32'(busy), 1);
        for (int i = 0; i < S; i++) begin
            stop = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        stop = 1'b0;
        if (hold) res_ready = 1'b0;
        for (int j = 0; j <= k; j++) begin
            samp.push_back(32'(v1));
            if (j == k) stop = 1'b1;
            else @(negedge clk);
        end
        // Reference: result is the sample at the stop cycle; flags from step rules.
        e.bin = W'(samp[k]);
        e.err = 1'b0;
        e.ovf = 1'b0;
        for (int i = 1; i <= k; i++) begin
            if (samp[i] != (samp[i-1] + 1) % (1 << W)) e.err = 1'b1;
            if (samp[i-1] == (1 << W) - 1 && samp[i] == 0) e.ovf = 1'b1;
        end
        if (use_c) e = cexp;
        exp_q.push_back(e);
        @(negedge clk);
        stop = 1'b0;
        chk("done_valid", 32'(res_valid), 1);
        chk("done_cnt_reset", 32'(cnt_reset), 1);
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                start = 1'($urandom_range(0, 1));
                stop  = 1'($urandom_range(0, 1));
                @(negedge clk);
                chk("hold_valid", 32'(res_valid), 1);
                chk("hold_busy", 32'(busy), 1);
                chk("hold_bin", 32'(res_bin), 32'(e.bin));
                chk("hold_err", 32'(res_err), 32'(e.err));
                chk("hold_ovf", 32'(res_ovf), 32'(e.ovf));
            end
            start     = 1'b0;
            stop      = 1'b0;
            res_ready = 1'b1;
            @(negedge clk);
            chk("ack_valid", 32'(res_valid), 0);
            chk("ack_busy", 32'(busy), 0);
        end else begin
            @(negedge clk);
            chk("one_cycle_done", 32'(res_valid), 0);
            chk("one_cycle_busy", 32'(busy), 0);
        end
        skip_en = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; stop = 1'b0; res_ready = 1'b1; skip_en = 1'b0;
        start3 = 1'b0; stop3 = 1'b0; ready3 = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cnt_reset", 32'(cnt_reset), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_bin", 32'(res_bin), 0);
        chk("rst_err", 32'(res_err), 0);
        chk("rst_ovf", 32'(res_ovf), 0);
        reset = 1'b0;

        measure(5, 1'b0, 1'b0, 1'b0, 1'b1, exp_t'{8'd5, 1'b0, 1'b0});
        measure(260, 1'b0, 1'b0, 1'b0, 1'b1, exp_t'{8'd4, 1'b0, 1'b1});
        measure(15, 1'b1, 1'b1, 1'b0, 1'b1, exp_t'{8'd16, 1'b1, 1'b0});
        measure(7, 1'b0, 1'b0, 1'b1, 1'b1, exp_t'{8'd7, 1'b0, 1'b0});

        // Abort in the middle of RUN.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (S + 4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_cnt_reset", 32'(cnt_reset), 1);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(res_valid), 0);
        chk("abort_bin", 32'(res_bin), 0);
        chk("abort_err", 32'(res_err), 0);
        chk("abort_ovf", 32'(res_ovf), 0);
        reset = 1'b0;
        measure(3, 1'b0, 1'b0, 1'b0, 1'b1, exp_t'{8'd3, 1'b0, 1'b0});

        for (int r = 0; r < 6; r++) begin
            measure(int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'b0, exp_t'{8'd0, 1'b0, 1'b0});
        end

        // Three settle cycles, start and stop together, stop held throughout.
        @(negedge clk);
        start3 = 1'b1;
        stop3  = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        chk("s3_cnt_reset", 32'(cr3), 0);
        chk("s3_busy", 32'(busy3), 1);
        n = 0;
        while (!rv3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("s3_latency", 32'(n), 4);
        chk("s3_bin", 32'(rb3), 2);
        chk("s3_err", 32'(re3), 0);
        chk("s3_ovf", 32'(ro3), 0);
        stop3 = 1'b0;

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gray_meas_ctrl.md
# gray_meas_ctrl

Sequencing controller for an 8-bit-class registered gray-code counter used as a cycle-duration timer. It holds the counter cleared while idle, releases it on `start`, checks every gray sample for a legal +1 step, and captures the gray-decoded count on `stop`. The captured result is presented through a valid/ready handshake with sticky error and overflow flags. It sits between the gray counter instance and the consumer of the measurement.

## Interface
- `WIDTH`, 8, counter width in bits; must match the driven counter.
- `SETTLE_CYCLES`, 1, cycles between counter release and the first RUN sample; range 1..15.
- `clk`  in  1  clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin measurement; honoured only in IDLE.
- `stop`  in  1  end measurement; honoured only in RUN.
- `gray_in`  in  WIDTH  gray-coded output of the counter.
- `cnt_reset`  out  1  registered reset to the counter; high holds it cleared.
- `busy`  out  1  high in any state other than IDLE.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `res_bin`  out  WIDTH  binary count captured on `stop`.
- `res_err`  out  1  a non-+1 step was seen during RUN.
- `res_ovf`  out  1  the count wrapped from all-ones to zero during RUN.

## Operation
- States: IDLE, SETTLE, RUN, DONE.
- IDLE: `cnt_reset`=1. If `start`=1, go to SETTLE, clear `res_err`/`res_ovf`, and load the settle counter with `SETTLE_CYCLES`-1.
- SETTLE: `cnt_reset`=0. Decrement the settle counter. At zero, go to RUN and mark the next sample as the reference.
- RUN: `cnt_reset`=0. Each cycle, compute b = gray2bin(`gray_in`): b[WIDTH-1] = g[WIDTH-1], and b[i] = b[i+1] ^ g[i].
  - The first RUN sample is the reference and is not checked.
  - For every later sample, b must equal (prev+1) mod 2^WIDTH; otherwise set `res_err` (sticky).
  - If prev = 2^WIDTH-1 and b = 0, set `res_ovf` (sticky).
  - On `stop`=1, capture b (after the same-cycle check) into `res_bin` and go to DONE.
- DONE: `res_valid`=1 and `cnt_reset`=1. `res_bin`, `res_err` and `res_ovf` hold stable. When `res_valid`&&`res_ready`, go to IDLE.
- Ignored events:
  - `start` outside IDLE.
  - `stop` outside RUN.
  - `stop` in the same cycle as `start` in IDLE (start wins; stop is dropped).
- `reset` in any state: next state IDLE. Outputs become `cnt_reset`=1, `busy`=0, `res_valid`=0, `res_bin`=0, `res_err`=0, `res_ovf`=0. Any in-flight measurement is discarded with no partial result.

## Timing
- All outputs are registered.
- `cnt_reset` falls on the edge that enters SETTLE.
- The counter's output lags its internal count by one cycle. With `SETTLE_CYCLES`=1, the first RUN sample is gray 0.
- The result equals the number of RUN cycles preceding the `stop` cycle (stop on RUN cycle k, 0-based, gives `res_bin`=k, modulo 2^WIDTH).
- `res_valid` rises one edge after the `stop` cycle. The transition from DONE to IDLE happens on the handshake edge.
- `start` is accepted again on the cycle after returning to IDLE. Minimum back-to-back period is SETTLE_CYCLES+3 cycles plus the RUN length.
- `res_ready` may be held high permanently; DONE then lasts exactly one cycle.

## Structure
- Package `gray_pkg`: state enum `gmc_state_t`, function `gray2bin` parameterised by width, and `bin2gray` for bench use.
- One natural sub-module: `gray_step_check`. It takes the current binary value plus a reference flag and outputs `err_step` and `wrap`, with the prev register inside. The FSM, settle counter and result registers stay in the top.

## Test plan
- Reset, then `start` → `cnt_reset` is 1 in IDLE and falls one edge later; first RUN `gray_in`=0; `stop` on RUN cycle 5 → `res_valid`=1, `res_bin`=5, `res_err`=0, `res_ovf`=0.
- WIDTH=8, `stop` on RUN cycle 260 → `res_bin`=4, `res_ovf`=1, `res_err`=0.
- Bench forces `gray_in` to skip from gray(9) to gray(11) → `res_err`=1 stays set through DONE; the next `start` clears it.
- Hold `res_ready`=0 for 10 cycles in DONE, toggle `start`/`stop` → outputs stable, state stays DONE; `res_ready`=1 → IDLE next cycle.
- Assert `reset` mid-RUN → all outputs reach reset values on the next edge; a subsequent measurement with `stop` on RUN cycle 3 returns 3.
- `start` and `stop` high together in IDLE → SETTLE entered, stop ignored; `SETTLE_CYCLES`=3 → RUN entered exactly 3 cycles after `cnt_reset` falls.
